mux41_scan_sampler: RTL and testbench

//   Sequential front/back-end for the 4:1 mux: round-robin arbitrates 4 request lines,

---
 rtl/mux41_scan_sampler.sv | 140 ++++++++++++++
 tb/tb_mux41_scan_sampler.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mux41_scan_sampler.sv
// Round-robin scan sampler wrapped around a 4:1 mux: picks a requesting channel,
// drives the mux select, waits HOLD_CYCLES for y to settle, then offers {chan, bit} downstream.
module mux41_scan_sampler #(
    parameter int HOLD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [1:0] s,
    input  logic       y,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_chan,
    output logic       out_bit,
    output logic       busy
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_PRESENT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       s_q, s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [1:0]       out_chan_q, out_chan_d;
    logic             out_bit_q, out_bit_d;
    logic [1:0]       last_grant_q, last_grant_d;
    logic [1:0]       grant_s;

    // The last granted channel gets lowest priority; scan starts just after it.
    function automatic logic [1:0] rr_grant(input logic [3:0] req_v, input logic [1:0] last_v);
        logic [1:0] g;
        logic [1:0] idx;
        logic       found;
        g     = last_v;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_v + 2'(k);
            if (!found && req_v[idx]) begin
                g     = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return g;
    endfunction

    // Round-robin grant from the current request vector.
    always_comb begin
        grant_s = rr_grant(req, last_grant_q);
    end

    // Next-state logic for the sampler FSM.
    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        out_chan_d   = out_chan_q;
        out_bit_d    = out_bit_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (req != 4'b0000) begin
                    s_d     = grant_s;
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    out_bit_d    = y;
                    out_chan_d   = s_q;
                    out_valid_d  = 1'b1;
                    last_grant_d = s_q;
                    state_d      = ST_PRESENT;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PRESENT: begin
                // grant_s already sees last_grant_q == presented channel here.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (req != 4'b0000) begin
                        s_d     = grant_s;
                        cnt_d   = '0;
                        state_d = ST_SETTLE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_PRESENT;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any pending sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            s_q          <= 2'd0;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_chan_q   <= 2'd0;
            out_bit_q    <= 1'b0;
            last_grant_q <= 2'd3;
        end else begin
            state_q      <= state_d;
            s_q          <= s_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_chan_q   <= out_chan_d;
            out_bit_q    <= out_bit_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign s         = s_q;
    assign out_valid = out_valid_q;
    assign out_chan  = out_chan_q;
    assign out_bit   = out_bit_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mux41_scan_sampler.sv
// Directed bench for mux41_scan_sampler with a behavioural 4:1 mux on y
// (inputs i0..i3 = 0,1,0,1, so the sampled bit equals the channel LSB).
module tb_mux41_scan_sampler;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [1:0] s;
    logic       y;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_chan;
    logic       out_bit;
    logic       busy;

    int chk_cnt = 0;
    int err_cnt = 0;

    localparam logic [3:0] MUX_IN = 4'b1010;
    assign y = MUX_IN[s];

    mux41_scan_sampler #(.HOLD_CYCLES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .s         (s),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_chan  (out_chan),
        .out_bit   (out_bit),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Advances at least one cycle, then waits (bounded) for the next presented sample.
    task automatic wait_sample(input logic [1:0] ech, input logic ebit);
        int n;
        n = 0;
        @(negedge clk);
        while (out_valid !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
        end
        check_eq("sample_valid", 32'(out_valid), 32'd1);
        check_eq("sample_chan", 32'(out_chan), 32'(ech));
        check_eq("sample_bit", 32'(out_bit), 32'(ebit));
    endtask

    initial begin
        logic [1:0] ech;
        rst       = 1'b1;
        req       = 4'b0000;
        out_ready = 1'b0;

        @(negedge clk);
        check_eq("rst_s", 32'(s), 32'd0);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_chan", 32'(out_chan), 32'd0);
        check_eq("rst_bit", 32'(out_bit), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // Single request on channel 1: exact latency and one-cycle valid.
        req       = 4'b0010;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("t1_s", 32'(s), 32'd1);
        check_eq("t1_busy", 32'(busy), 32'd1);
        check_eq("t1_valid_c1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check_eq("t1_valid_c2", 32'(out_valid), 32'd0);
        @(negedge clk);
        check_eq("t1_valid_c3", 32'(out_valid), 32'd1);
        check_eq("t1_chan", 32'(out_chan), 32'd1);
        check_eq("t1_bit", 32'(out_bit), 32'd1);
        req = 4'b0000;
        @(negedge clk);
        check_eq("t1_valid_drop", 32'(out_valid), 32'd0);
        check_eq("t1_idle", 32'(busy), 32'd0);

        // All requests: 0,1,2,3,0 one sample every 3 cycles, busy never drops.
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            ech = 2'(i);
            for (int j = 0; j < 2; j++) begin
                @(negedge clk);
                check_eq("t2_gap_valid", 32'(out_valid), 32'd0);
                check_eq("t2_gap_busy", 32'(busy), 32'd1);
            end
            @(negedge clk);
            check_eq("t2_valid", 32'(out_valid), 32'd1);
            check_eq("t2_chan", 32'(out_chan), 32'(ech));
            check_eq("t2_bit", 32'(out_bit), 32'(ech[0]));
            check_eq("t2_busy", 32'(busy), 32'd1);
        end

        // Backpressure while presenting channel 0.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("t3_hold_valid", 32'(out_valid), 32'd1);
            check_eq("t3_hold_chan", 32'(out_chan), 32'd0);
            check_eq("t3_hold_bit", 32'(out_bit), 32'd0);
            check_eq("t3_hold_s", 32'(s), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("t3_release_valid", 32'(out_valid), 32'd0);
        check_eq("t3_release_s", 32'(s), 32'd1);
        wait_sample(2'd1, 1'b1);
        wait_sample(2'd2, 1'b0);
        wait_sample(2'd3, 1'b1);

        // Wrap from channel 3 with only channels 0 and 3 requesting.
        req = 4'b1001;
        wait_sample(2'd0, 1'b0);
        wait_sample(2'd3, 1'b1);
        wait_sample(2'd0, 1'b0);
        wait_sample(2'd3, 1'b1);

        // One-cycle pulse on channel 2 is still served, then back to idle.
        req = 4'b0000;
        @(negedge clk);
        check_eq("t5_idle_busy", 32'(busy), 32'd0);
        check_eq("t5_idle_valid", 32'(out_valid), 32'd0);
        req = 4'b0100;
        @(negedge clk);
        req = 4'b0000;
        check_eq("t5_s", 32'(s), 32'd2);
        check_eq("t5_busy", 32'(busy), 32'd1);
        wait_sample(2'd2, 1'b0);
        @(negedge clk);
        check_eq("t5_after_valid", 32'(out_valid), 32'd0);
        check_eq("t5_after_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check_eq("t5_stay_idle", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of SETTLE.
        do_reset();
        req = 4'b1111;
        wait_sample(2'd0, 1'b0);
        wait_sample(2'd1, 1'b1);
        @(negedge clk);
        check_eq("t6_pre_s", 32'(s), 32'd2);
        check_eq("t6_pre_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t6_rst_s", 32'(s), 32'd0);
        check_eq("t6_rst_busy", 32'(busy), 32'd0);
        check_eq("t6_rst_valid", 32'(out_valid), 32'd0);
        check_eq("t6_rst_chan", 32'(out_chan), 32'd0);
        check_eq("t6_rst_bit", 32'(out_bit), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_sample(2'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
